// File: rtl/apb3_accel_bridge_if.sv
// APB3 bus bundle between the SoC decoder (master) and the accelerator bridge (slave).
interface apb3_accel_bridge_if #(
    parameter int unsigned ADDR_W = 8
) ();
    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PWDATA;
    logic              PREADY;
    logic [31:0]       PRDATA;
    logic              PSLVERROR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PREADY, PRDATA, PSLVERROR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PREADY, PRDATA, PSLVERROR
    );
endinterface

// File: rtl/apb3_accel_bridge.sv
// APB3 slave feeding an XMSS hash/chain accelerator: byte-swapped input bank, launch FSM,
// stable result buffer, sticky status and irq. Define APB3_ACCEL_TIMEOUT_EN for the watchdog.
module apb3_accel_bridge #(
    parameter int unsigned IN_WORDS       = 32,
    parameter int unsigned OUT_WORDS      = 8,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned CMD_W          = 3,
    parameter int unsigned STEP_W         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                      io_mainClk,
    input  logic                      io_systemReset_n,
    apb3_accel_bridge_if.slave        io_apb,
    output logic [CMD_W-1:0]          acc_cmd,
    output logic [IN_WORDS*32-1:0]    acc_data,
    output logic [STEP_W-1:0]         acc_start_step,
    output logic [STEP_W-1:0]         acc_end_step,
    output logic                      acc_start,
    input  logic                      acc_done,
    input  logic [OUT_WORDS*32-1:0]   acc_result,
    output logic                      irq
);

    typedef enum logic [1:0] {StIdle, StLaunch, StBusy, StDone} state_e;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    state_e             state_q, state_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic               auto_q, auto_d;
    logic               irq_en_q, irq_en_d;
    logic [STEP_W-1:0]  sstep_q, sstep_d;
    logic [STEP_W-1:0]  estep_q, estep_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [31:0]        bank_q [IN_WORDS];
    logic [31:0]        bank_d [IN_WORDS];
    logic [31:0]        obuf_q [OUT_WORDS];
    logic [31:0]        obuf_d [OUT_WORDS];

`ifdef APB3_ACCEL_TIMEOUT_EN
    logic               tmo_q, tmo_d;
    logic [31:0]        cnt_q, cnt_d;
    logic               tmo_hit;
`endif

    // Address decode
    logic        access;
    logic [31:0] paddr32;
    logic [31:0] word_idx;
    logic        aligned, is_status, is_ctrl, is_step, is_word, mapped;

    assign access    = io_apb.PSEL & io_apb.PENABLE;
    assign paddr32   = 32'(io_apb.PADDR);
    assign word_idx  = (paddr32 - 32'd16) >> 2;
    assign aligned   = (paddr32[1:0] == 2'b00);
    assign is_status = (paddr32 == 32'h0);
    assign is_ctrl   = (paddr32 == 32'h4);
    assign is_step   = (paddr32 == 32'h8);
    assign is_word   = aligned && (paddr32 >= 32'd16) && (paddr32 < 32'(16 + 4 * IN_WORDS));
    assign mapped    = is_status | is_ctrl | is_step | is_word;

    logic busy;
    assign busy = (state_q == StLaunch) || (state_q == StBusy);

    logic             fin_ok;
    assign fin_ok = acc_done & busy;

    logic [CMD_W-1:0] ctrl_cmd, new_cmd;
    logic             ctrl_start, ctrl_clear;
    assign ctrl_cmd   = io_apb.PWDATA[CMD_W+7:8];
    assign new_cmd    = (ctrl_cmd != '0) ? ctrl_cmd : cmd_q;
    assign ctrl_start = io_apb.PWDATA[0];
    assign ctrl_clear = io_apb.PWDATA[31];

    logic launch_req, clear_req, slv_err;

    // Register next-state and APB write side effects
    always_comb begin
        cmd_d      = cmd_q;
        auto_d     = auto_q;
        irq_en_d   = irq_en_q;
        sstep_d    = sstep_q;
        estep_d    = estep_q;
        done_d     = done_q;
        err_d      = err_q;
        bank_d     = bank_q;
        obuf_d     = obuf_q;
        launch_req = 1'b0;
        clear_req  = 1'b0;
        slv_err    = 1'b0;
`ifdef APB3_ACCEL_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        if (access) begin
            if (!mapped) begin
                slv_err = 1'b1;
            end else if (io_apb.PWRITE) begin
                if (is_status) begin
                    slv_err = 1'b1;
                end else if (is_ctrl) begin
                    if (busy) begin
                        // Only a pure clear may touch CTRL while the accelerator runs
                        if (ctrl_clear && !ctrl_start) begin
                            done_d = 1'b0;
                            err_d  = 1'b0;
`ifdef APB3_ACCEL_TIMEOUT_EN
                            tmo_d  = 1'b0;
`endif
                        end else begin
                            slv_err = 1'b1;
                            err_d   = 1'b1;
                        end
                    end else begin
                        cmd_d    = new_cmd;
                        auto_d   = io_apb.PWDATA[1];
                        irq_en_d = io_apb.PWDATA[2];
                        if (ctrl_clear) begin
                            done_d = 1'b0;
                            err_d  = 1'b0;
`ifdef APB3_ACCEL_TIMEOUT_EN
                            tmo_d  = 1'b0;
`endif
                            clear_req = !ctrl_start;
                        end
                        if (ctrl_start) begin
                            if (new_cmd != '0) begin
                                launch_req = 1'b1;
                            end else begin
                                slv_err = 1'b1;
                                err_d   = 1'b1;
                            end
                        end
                    end
                end else if (busy) begin
                    slv_err = 1'b1;
                    err_d   = 1'b1;
                end else if (is_step) begin
                    sstep_d = io_apb.PWDATA[STEP_W+7:8];
                    estep_d = io_apb.PWDATA[STEP_W+15:16];
                end else begin
                    for (int i = 0; i < IN_WORDS; i++) begin
                        if (word_idx == 32'(i)) bank_d[i] = bswap(io_apb.PWDATA);
                    end
                    if (word_idx == 32'(IN_WORDS - 1) && auto_q && cmd_q != '0) begin
                        launch_req = 1'b1;
                    end
                end
            end
        end
        if (fin_ok) begin
            for (int i = 0; i < OUT_WORDS; i++) begin
                obuf_d[i] = acc_result[OUT_WORDS*32-1-32*i -: 32];
            end
            done_d = 1'b1;
        end
`ifdef APB3_ACCEL_TIMEOUT_EN
        if (tmo_hit) begin
            done_d = 1'b1;
            err_d  = 1'b1;
            tmo_d  = 1'b1;
        end
`endif
    end

`ifdef APB3_ACCEL_TIMEOUT_EN
    // acc_done in the expiry cycle takes priority as a normal completion
    assign tmo_hit = (state_q == StBusy) && !acc_done &&
                     ((cnt_q + 32'd1) == 32'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StLaunch) cnt_d = 32'd0;
        else if (state_q == StBusy) cnt_d = cnt_q + 32'd1;
    end
`endif

    // FSM: state register
    always_ff @(posedge io_mainClk or negedge io_systemReset_n) begin
        if (!io_systemReset_n) state_q <= StIdle;
        else                   state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (launch_req) state_d = StLaunch;
            StLaunch: state_d = acc_done ? StDone : StBusy;
            StBusy: begin
                if (acc_done) state_d = StDone;
`ifdef APB3_ACCEL_TIMEOUT_EN
                else if (tmo_hit) state_d = StDone;
`endif
            end
            StDone: begin
                if (launch_req)     state_d = StLaunch;
                else if (clear_req) state_d = StIdle;
            end
            default:  state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        acc_start = (state_q == StLaunch);
    end

    always_ff @(posedge io_mainClk or negedge io_systemReset_n) begin
        if (!io_systemReset_n) begin
            cmd_q    <= '0;
            auto_q   <= 1'b0;
            irq_en_q <= 1'b0;
            sstep_q  <= '0;
            estep_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            bank_q   <= '{default: '0};
            obuf_q   <= '{default: '0};
`ifdef APB3_ACCEL_TIMEOUT_EN
            tmo_q    <= 1'b0;
            cnt_q    <= '0;
`endif
        end else begin
            cmd_q    <= cmd_d;
            auto_q   <= auto_d;
            irq_en_q <= irq_en_d;
            sstep_q  <= sstep_d;
            estep_q  <= estep_d;
            done_q   <= done_d;
            err_q    <= err_d;
            bank_q   <= bank_d;
            obuf_q   <= obuf_d;
`ifdef APB3_ACCEL_TIMEOUT_EN
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Read path
    logic [31:0] status, rdata;
    always_comb begin
        status              = 32'd0;
        status[0]           = busy;
        status[1]           = done_q;
        status[2]           = err_q;
`ifdef APB3_ACCEL_TIMEOUT_EN
        status[3]           = tmo_q;
`endif
        status[CMD_W+7:8]   = cmd_q;
        rdata               = 32'd0;
        if (is_status) begin
            rdata = status;
        end else if (is_word) begin
            for (int i = 0; i < OUT_WORDS; i++) begin
                if (word_idx == 32'(i)) rdata = bswap(obuf_q[i]);
            end
        end
    end

    assign io_apb.PREADY    = 1'b1;
    assign io_apb.PSLVERROR = slv_err;
    assign io_apb.PRDATA    = (slv_err || io_apb.PWRITE) ? 32'd0 : rdata;

    always_comb begin
        acc_data = '0;
        for (int i = 0; i < IN_WORDS; i++) begin
            acc_data[IN_WORDS*32-1-32*i -: 32] = bank_q[i];
        end
    end

    assign acc_cmd        = cmd_q;
    assign acc_start_step = sstep_q;
    assign acc_end_step   = estep_q;
    assign irq            = done_q & irq_en_q;

endmodule

// File: tb/tb_apb3_accel_bridge.sv
// Directed bench for apb3_accel_bridge: APB driver, result scoreboard, immediate-assert checks.
module tb_apb3_accel_bridge;

    localparam int unsigned IN_WORDS  = 32;
    localparam int unsigned OUT_WORDS = 8;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned CMD_W     = 3;
    localparam int unsigned STEP_W    = 4;
    localparam int unsigned TMO       = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb3_accel_bridge_if #(.ADDR_W(ADDR_W)) apb ();

    logic [CMD_W-1:0]         acc_cmd;
    logic [IN_WORDS*32-1:0]   acc_data;
    logic [STEP_W-1:0]        acc_start_step;
    logic [STEP_W-1:0]        acc_end_step;
    logic                     acc_start;
    logic                     acc_done;
    logic [OUT_WORDS*32-1:0]  acc_result;
    logic                     irq;

    apb3_accel_bridge #(
        .IN_WORDS(IN_WORDS), .OUT_WORDS(OUT_WORDS), .ADDR_W(ADDR_W),
        .CMD_W(CMD_W), .STEP_W(STEP_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .io_mainClk       (clk),
        .io_systemReset_n (rst_n),
        .io_apb           (apb),
        .acc_cmd          (acc_cmd),
        .acc_data         (acc_data),
        .acc_start_step   (acc_start_step),
        .acc_end_step     (acc_end_step),
        .acc_start        (acc_start),
        .acc_done         (acc_done),
        .acc_result       (acc_result),
        .irq              (irq)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    logic [31:0] res_q [$];
    logic [31:0] rd;
    logic        er;

    function automatic logic [31:0] swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err);
        @(posedge clk); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr;
        apb.PADDR = addr; apb.PWDATA = wdata;
        @(posedge clk); #1;
        apb.PENABLE = 1'b1;
        @(negedge clk);
        rdata = apb.PRDATA;
        err   = apb.PSLVERROR;
        @(posedge clk); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] addr, input logic [31:0] d, input logic exp_err,
                      input string tag);
        logic [31:0] r;
        logic        e;
        xfer(1'b1, addr, d, r, e);
        check(tag, {31'd0, e}, {31'd0, exp_err});
    endtask

    task automatic rd_exp(input logic [ADDR_W-1:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] r;
        logic        e;
        xfer(1'b0, addr, 32'd0, r, e);
        check(tag, r, exp);
    endtask

    // Pops the oldest expected result pushed when the accelerator completed
    task automatic rd_res(input logic [ADDR_W-1:0] addr, input string tag);
        logic [31:0] r;
        logic        e;
        xfer(1'b0, addr, 32'd0, r, e);
        if (res_q.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
        else check(tag, r, res_q.pop_front());
    endtask

    task automatic complete(input logic [31:0] w0, input logic [31:0] w1, input logic push);
        acc_result = '0;
        acc_result[OUT_WORDS*32-1 -: 32] = w0;
        acc_result[OUT_WORDS*32-33 -: 32] = w1;
        if (push) begin
            res_q.push_back(swap(w0));
            res_q.push_back(swap(w1));
        end
        acc_done = 1'b1;
        @(posedge clk); #1;
        acc_done = 1'b0;
    endtask

    initial begin
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = '0; apb.PWDATA = '0;
        acc_done = 1'b0; acc_result = '0;
        repeat (3) @(posedge clk);
        check("rst_acc_start", {31'd0, acc_start}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        #1 rst_n = 1'b1;
        check("pready", {31'd0, apb.PREADY}, 32'd1);
        rd_exp(8'h00, 32'h0, "status_rst");
        rd_exp(8'h10, 32'h0, "res0_rst");

        wr(8'h10, 32'h11223344, 1'b0, "wr_w0");
        check("acc_data_w0", acc_data[IN_WORDS*32-1 -: 32], 32'h44332211);
        xfer(1'b0, 8'h0C, 32'd0, rd, er);
        check("unmapped_err", {31'd0, er}, 32'd1);
        check("unmapped_data", rd, 32'd0);
        wr(8'h00, 32'hFFFF_FFFF, 1'b1, "wr_status_ro");

        wr(8'h08, 32'h000F0200, 1'b0, "wr_step");
        check("start_step", 32'(acc_start_step), 32'd2);
        check("end_step", 32'(acc_end_step), 32'd15);
        wr(8'h04, 32'h00000205, 1'b0, "ctrl_start");
        check("launch_pulse", {31'd0, acc_start}, 32'd1);
        check("acc_cmd", 32'(acc_cmd), 32'd2);
        @(posedge clk); #1;
        check("pulse_one_cycle", {31'd0, acc_start}, 32'd0);
        complete(32'hAABBCCDD, 32'h01020304, 1'b1);
        rd_exp(8'h00, 32'h00000202, "status_done");
        rd_res(8'h10, "res_w0");
        rd_res(8'h14, "res_w1");
        check("irq_done", {31'd0, irq}, 32'd1);
        wr(8'h04, 32'h80000000, 1'b0, "ctrl_clear");
        rd_exp(8'h00, 32'h00000200, "status_cleared");
        check("irq_cleared", {31'd0, irq}, 32'd0);

        // Relaunch keeping cmd, then poke registers while busy
        wr(8'h04, 32'h00000001, 1'b0, "relaunch");
        check("relaunch_pulse", {31'd0, acc_start}, 32'd1);
        wr(8'h14, 32'h12345678, 1'b1, "busy_wr_word");
        check("busy_word_kept", acc_data[IN_WORDS*32-33 -: 32], 32'd0);
        wr(8'h08, 32'h00030100, 1'b1, "busy_wr_step");
        check("busy_step_kept", 32'(acc_start_step), 32'd2);
        rd_exp(8'h00, 32'h00000205, "status_busy_err");
        wr(8'h04, 32'h80000000, 1'b0, "busy_clear_only");
        rd_exp(8'h00, 32'h00000201, "status_busy_clr");
        complete(32'h55667788, 32'h0, 1'b1);
        rd_res(8'h10, "res2_w0");
        rd_res(8'h14, "res2_w1");
        complete(32'hDEADBEEF, 32'h0, 1'b0);
        rd_exp(8'h10, 32'h88776655, "done_ignored");
        rd_exp(8'h00, 32'h00000202, "status_done2");

        // auto_start on the last input word; acc_done in the launch cycle
        wr(8'h04, 32'h80000102, 1'b0, "auto_cfg");
        rd_exp(8'h00, 32'h00000100, "status_auto_idle");
        wr(8'h8C, 32'hCAFEF00D, 1'b0, "auto_word");
        check("auto_pulse", {31'd0, acc_start}, 32'd1);
        check("auto_cmd", 32'(acc_cmd), 32'd1);
        check("last_word", acc_data[31:0], 32'h0DF0FECA);
        complete(32'h0A0B0C0D, 32'h0, 1'b1);
        check("auto_pulse_end", {31'd0, acc_start}, 32'd0);
        rd_exp(8'h00, 32'h00000102, "status_auto_done");
        rd_res(8'h10, "res3_w0");
        rd_res(8'h14, "res3_w1");

        // Asynchronous reset cuts a launch in progress
        wr(8'h04, 32'h00000105, 1'b0, "launch_pre_rst");
        check("pre_rst_pulse", {31'd0, acc_start}, 32'd1);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_cut_pulse", {31'd0, acc_start}, 32'd0);
        check("rst_irq0", {31'd0, irq}, 32'd0);
        check("rst_cmd0", 32'(acc_cmd), 32'd0);
        check("rst_data0", {31'd0, |acc_data}, 32'd0);
        check("rst_step0", 32'(acc_end_step), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        wr(8'h04, 32'h00000001, 1'b1, "start_cmd0");
        check("cmd0_no_pulse", {31'd0, acc_start}, 32'd0);
        rd_exp(8'h00, 32'h00000004, "status_cmd0_err");

`ifdef APB3_ACCEL_TIMEOUT_EN
        wr(8'h04, 32'h80000300, 1'b0, "tmo_cfg");
        wr(8'h04, 32'h00000001, 1'b0, "tmo_launch");
        repeat (TMO + 1) @(posedge clk);
        #1;
        rd_exp(8'h00, 32'h0000030E, "status_timeout");
        rd_exp(8'h10, 32'h0, "tmo_obuf_kept");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/apb3_accel_bridge.md
Name: apb3_accel_bridge

Overview:
- Parametrised APB3 slave that succeeds the fixed-width gen_chain bridge.
- Holds a byte-swapped input word bank and command/step registers. Launches the hash/chain accelerator through a small state machine and captures its result into a stable readback buffer.
- Provides sticky done/error status and an interrupt.
- Sits between the SoC APB decoder and any XMSS hash/chain accelerator core.

Parameters:
- IN_WORDS, 32, number of 32-bit input words (accelerator input = IN_WORDS*32 bits).
- OUT_WORDS, 8, number of 32-bit result words (OUT_WORDS <= IN_WORDS).
- ADDR_W, 8, APB address width; 16 + 4*IN_WORDS must be <= 2^ADDR_W.
- CMD_W, 3, accelerator command width.
- STEP_W, 4, chain step field width.
- TIMEOUT_CYCLES, 65535, watchdog limit; used only with the optional feature.

Ports:
- io_mainClk  in  1  clock.
- io_systemReset_n  in  1  asynchronous active-low reset.
- io_apb_PADDR  in  ADDR_W  byte address.
- io_apb_PSEL  in  1  select.
- io_apb_PENABLE  in  1  access phase.
- io_apb_PWRITE  in  1  write.
- io_apb_PWDATA  in  32  write data.
- io_apb_PREADY  out  1  constant 1 (zero wait states).
- io_apb_PRDATA  out  32  read data (combinational).
- io_apb_PSLVERROR  out  1  access error (combinational, access phase only).
- acc_cmd  out  CMD_W  command to accelerator.
- acc_data  out  IN_WORDS*32  input bank; word 0 = MSB slice.
- acc_start_step  out  STEP_W  chain start step.
- acc_end_step  out  STEP_W  chain end step.
- acc_start  out  1  one-cycle launch pulse.
- acc_done  in  1  one-cycle completion pulse.
- acc_result  in  OUT_WORDS*32  result, valid in the acc_done cycle.
- irq  out  1  level interrupt = done_sticky & irq_en.

Behaviour:
- Access is valid when PSEL & PENABLE. Writes commit at the clock edge of the access phase.
- Address map:
  - 0x00 STATUS (read): bit0 busy (state LAUNCH/BUSY); bit1 done_sticky; bit2 err_sticky; bit3 timeout; bits[CMD_W+7:8] current cmd.
  - 0x04 CTRL (write): bit0 start; bit1 auto_start; bit2 irq_en; bits[CMD_W+7:8] cmd, where 0 keeps the previous cmd; bit31 clear (done/err/timeout sticky -> 0).
  - 0x08 STEP (write): start_step = PWDATA[STEP_W+7:8]; end_step = PWDATA[STEP_W+15:16].
  - 0x10+4i: write stores input word i byte-reversed ({B0,B1,B2,B3}). Read for i < OUT_WORDS returns result word i of out_buf, byte-reversed; word 0 is the MSB slice.
  - Unmapped address, or a write to a read-only location: PSLVERROR=1, no state change, PRDATA=0.
- Reset values: all registers 0; acc_start=0; irq=0; state IDLE; cmd=0; auto_start=0; irq_en=0.
- FSM states IDLE, LAUNCH, BUSY, DONE:
  - IDLE or DONE -> LAUNCH on a CTRL write with start=1 and resulting cmd != 0. The same write also applies cmd, irq_en and auto_start.
  - IDLE or DONE -> LAUNCH on a write to word IN_WORDS-1 while auto_start=1 and cmd != 0.
  - LAUNCH: acc_start=1 for exactly this cycle; next state is BUSY.
  - BUSY -> DONE on acc_done. acc_done is also honoured in the LAUNCH cycle, going straight to DONE.
  - On entry to DONE: out_buf <= acc_result[OUT_WORDS*32-1:0] (latched in the acc_done cycle); done_sticky <= 1.
  - DONE -> IDLE on a CTRL write with clear=1 and start=0. clear=1 together with start=1 clears stickies and launches.
- Start requested with resulting cmd == 0: ignored, err_sticky <= 1, PSLVERROR=1.
- While in LAUNCH or BUSY, writes to CTRL (except a clear-only write), STEP or the input bank are dropped, with PSLVERROR=1 and err_sticky <= 1. Reads are always allowed; out_buf keeps the previous result.
- acc_done while in IDLE or DONE: ignored; out_buf unchanged.
- Reset asserted mid-operation: immediate return to the reset state; any acc_start pulse is cut.
- Latency: 1 cycle from the start write edge to acc_start high; result readable on the first cycle after acc_done.

Optional Feature:
- Macro APB3_ACCEL_TIMEOUT_EN.
- Defined: a 32-bit counter clears on LAUNCH and increments in BUSY. On reaching TIMEOUT_CYCLES, the FSM goes to DONE with timeout=1, done_sticky=1, err_sticky=1, and out_buf not updated. An acc_done in the same cycle wins, giving a normal completion.
- Not defined: no counter; BUSY waits indefinitely; STATUS bit3 reads 0.

Test Plan:
- Reset, then read 0x00 -> 0x00000000; read 0x10 -> 0; irq=0.
- Write 0x10 = 0x11223344 -> acc_data[IN_WORDS*32-1 -: 32] = 0x44332211.
- Write 0x08 = 0x000F0200, then 0x04 = 0x00000205 -> acc_start_step=2, end_step=15, cmd=2, acc_start one cycle later. Then acc_done with result word0 = 0xAABBCCDD -> STATUS = 0x00000202, read 0x10 = 0xDDCCBBAA, irq=1.
- While BUSY, write 0x14 -> PSLVERROR=1, word 1 unchanged, STATUS bit2=1. Then write 0x04 = 0x80000000 after done -> STATUS bits[3:0] = 0, state IDLE, irq=0.
- auto_start=1, cmd=1: write word IN_WORDS-1 -> acc_start pulse next cycle. Start with cmd=0 from reset -> no pulse, err_sticky=1.
- With APB3_ACCEL_TIMEOUT_EN and TIMEOUT_CYCLES=16: start, no acc_done -> after 16 BUSY cycles STATUS bit3=1, bit1=1, out_buf unchanged. Assert io_systemReset_n=0 mid-BUSY -> all outputs 0 immediately.
